// File: rtl/key_scan_display.sv
// key_scan_display
//   Debounces N_KEYS active-low push buttons, builds a hex nibble from the four
//   data keys and drives an N_DIGITS multiplexed 7-segment display from an
//   internal scan tick. A mode key cycles single / mirror-scan / shift-entry;
//   the enter key shifts the nibble into an N_DIGITS entry buffer in entry mode.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   key        raw buttons, 0 = pressed, asynchronous to clk
//   cs         one-hot digit select (inverted when SEG_ACTIVE_LOW)
//   seg        segments {dp,g,f,e,d,c,b,a} (inverted when SEG_ACTIVE_LOW)
//   key_state  debounced level per key, 1 = pressed
//   key_press  one-cycle pulse per key on each debounced press
//   mode       0 single, 1 mirror, 2 entry
module key_scan_display #(
  parameter int F_CLK          = 50000000,
  parameter int F_SCAN         = 1000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int N_KEYS         = 6,
  parameter int N_DIGITS       = 8,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_KEYS-1:0]   key,
  output logic [N_DIGITS-1:0] cs,
  output logic [7:0]          seg,
  output logic [N_KEYS-1:0]   key_state,
  output logic [N_KEYS-1:0]   key_press,
  output logic [1:0]          mode
);

  localparam int TICK_DIV  = F_CLK / F_SCAN;
  localparam int DB_CYCLES = F_CLK / 1000 * DEBOUNCE_MS;
  localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int PTR_W     = $clog2(N_DIGITS);
  localparam int CNT_W     = $clog2(N_DIGITS + 1);
  localparam int BUF_W     = N_DIGITS * 4;
  localparam bit INV       = (SEG_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_MIRROR = 2'd1,
    MODE_ENTRY  = 2'd2
  } mode_e;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    hex_font = 7'h00;
    case (n)
      4'h0: hex_font = 7'h3F;  4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;  4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;  4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;  4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;  4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;  4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;  4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;  4'hF: hex_font = 7'h71;
    endcase
  endfunction

  // ---------------------------------------------------------------- debounce
  // Synchroniser stores the inverted (pressed = 1) level directly.
  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] state_q, state_dly_q, press_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      state_dly_q <= '0;
      press_q     <= '0;
    end else begin
      sync1_q     <= ~key;
      sync2_q     <= sync1_q;
      state_dly_q <= state_q;
      press_q     <= state_q & ~state_dly_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_db
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            st_q, st_d;

      // Counter only runs while the synced level disagrees with the
      // debounced level, so any agreement restarts the window.
      always_comb begin
        cnt_d = '0;
        st_d  = st_q;
        if (sync2_q[gi] != st_q) begin
          if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
            st_d = ~st_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
          st_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          st_q  <= st_d;
        end
      end

      assign state_q[gi] = st_q;
    end
  endgenerate

  assign key_state = state_q;
  assign key_press = press_q;

  // --------------------------------------------------------------- scan tick
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;

  assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // ------------------------------------------------------- mode FSM + display
  mode_e               mode_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [BUF_W-1:0]    buf_q;
  logic [CNT_W-1:0]    entry_cnt_q;
  logic [N_DIGITS-1:0] cs_q;
  logic [7:0]          seg_q;

  logic [3:0]          nib;
  logic [3:0]          digit_nib;
  logic                digit_on;
  logic                digit_dp;
  logic [7:0]          seg_raw;
  logic [N_DIGITS-1:0] cs_raw;

  assign nib = state_q[3:0];

  always_comb begin
    digit_nib = nib;
    digit_on  = 1'b1;
    digit_dp  = state_q[4];
    if (mode_q == MODE_ENTRY) begin
      digit_nib = buf_q[{ptr_q, 2'b00} +: 4];
      digit_dp  = 1'b0;
      // Digits not yet filled stay dark while the scan still visits them.
      digit_on  = (CNT_W'(ptr_q) < entry_cnt_q);
    end
    seg_raw = digit_on ? {digit_dp, hex_font(digit_nib)} : 8'h00;
    cs_raw  = '0;
    cs_raw[ptr_q] = 1'b1;
  end

  // Shift and pointer decisions use the pre-transition mode, so a
  // simultaneous enter + mode press shifts only if already in entry mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_SINGLE;
      ptr_q       <= '0;
      buf_q       <= '0;
      entry_cnt_q <= '0;
      cs_q        <= {N_DIGITS{INV}};
      seg_q       <= {8{INV}};
    end else begin
      if (press_q[4] && (mode_q == MODE_ENTRY)) begin
        buf_q <= {buf_q[BUF_W-5:0], nib};
        if (entry_cnt_q != CNT_W'(N_DIGITS)) entry_cnt_q <= entry_cnt_q + 1'b1;
      end

      if (press_q[5]) begin
        case (mode_q)
          MODE_SINGLE: mode_q <= MODE_MIRROR;
          MODE_MIRROR: mode_q <= MODE_ENTRY;
          default:     mode_q <= MODE_SINGLE;
        endcase
      end

      if (mode_q == MODE_SINGLE) begin
        ptr_q <= '0;
      end else if (tick) begin
        ptr_q <= (ptr_q == PTR_W'(N_DIGITS - 1)) ? '0 : ptr_q + 1'b1;
      end

      cs_q  <= cs_raw ^ {N_DIGITS{INV}};
      seg_q <= seg_raw ^ {8{INV}};
    end
  end

  assign cs   = cs_q;
  assign seg  = seg_q;
  assign mode = mode_q;

endmodule

// File: doc/key_scan_display.md
Name: key_scan_display

Overview:
- Parametrised successor of the single-nibble key/7-segment scanner.
- Debounces N_KEYS raw active-low push buttons and builds a hex nibble from the four data keys.
- Drives an N_DIGITS multiplexed 7-segment display from an internal scan tick; no derived clocks.
- Adds a three-mode state machine (single, mirror-scan, shift-entry), an N_DIGITS nibble entry buffer, and per-key debounced-level and press-pulse outputs for other blocks.

Parameters:
- F_CLK, 50000000, system clock frequency in Hz.
- F_SCAN, 1000, digit-advance rate in Hz; TICK_DIV = F_CLK/F_SCAN.
- DEBOUNCE_MS, 20, stability window; DB_CYCLES = F_CLK/1000*DEBOUNCE_MS.
- N_KEYS, 6, number of raw keys; minimum 6.
- N_DIGITS, 8, number of display digits; range 2..16.
- SEG_ACTIVE_LOW, 1, when 1, seg and cs are inverted (low = lit/selected).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key  in  N_KEYS  raw buttons, 0 = pressed, asynchronous to clk
- cs  out  N_DIGITS  one-hot digit select
- seg  out  8  segments {dp,g,f,e,d,c,b,a}
- key_state  out  N_KEYS  debounced level, 1 = pressed
- key_press  out  N_KEYS  one-cycle pulse on each debounced press edge
- mode  out  2  current mode: 0 single, 1 mirror, 2 entry

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On rst all state clears immediately, mid-operation included:
  - key_state = 0, key_press = 0, mode = 0, scan pointer = 0, tick counter = 0, buffer = 0, entry_cnt = 0.
  - cs = all deselected, seg = all off (all ones when SEG_ACTIVE_LOW = 1).
- Debounce, per key:
  - Raw key passes through a 2-FF synchroniser and is inverted to form the pressed level.
  - A per-key counter increments while the synced level differs from key_state and clears to 0 whenever they agree.
  - When the count reaches DB_CYCLES-1, key_state toggles and the counter clears. Glitches shorter than DB_CYCLES never toggle key_state.
  - key_press[i] is high for exactly one cycle, on the cycle after key_state[i] goes 0 to 1. Releases produce no pulse.
- Key roles:
  - key[3:0] are data keys; nib = key_state[3:0], with key[3] as MSB.
  - key[4] is dot/enter.
  - key[5] is mode.
  - key[N_KEYS-1:6] are debounced and exported only.
- Mode FSM:
  - On key_press[5], mode advances 0 to 1 to 2 to 0. There are no other transitions.
  - Switching modes retains the buffer and entry_cnt.
- Scan tick:
  - Free-running counter 0..TICK_DIV-1; tick is asserted for one cycle when the counter is at TICK_DIV-1, then the counter wraps to 0.
  - Pointer width is clog2(N_DIGITS).
  - In mode 0, the pointer is held at 0.
  - In modes 1 and 2, the pointer increments on tick and wraps from N_DIGITS-1 to 0.
- Entry buffer (mode 2 only):
  - On key_press[4], the buffer shifts one nibble toward higher digit indices, the top nibble is discarded, and digit0 loads nib.
  - entry_cnt increments and saturates at N_DIGITS.
  - In modes 0 and 1, key_press[4] does not alter the buffer.
- Simultaneous key_press[4] and key_press[5]: the shift is evaluated with the pre-transition mode, and the mode still advances.
- Digit content:
  - Mode 0: digit 0 shows nib; dp is lit while key_state[4] = 1.
  - Mode 1: every scanned digit shows nib, same dp rule as mode 0.
  - Mode 2: digit p shows buffer[p] with dp off; digits with p >= entry_cnt are blank (all segments off) while cs still scans.
- Hex font, active-high, a = bit0:
  - 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07
  - 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71
- Outputs:
  - cs and seg are registered; each reflects the pointer and content of the previous cycle (1-cycle latency).
  - cs always has exactly one digit selected after the first post-reset cycle.
  - When SEG_ACTIVE_LOW = 1, both cs and seg are inverted.

Test Plan (bench params: F_CLK=100000, F_SCAN=10000, DEBOUNCE_MS=1, so TICK_DIV=10, DB_CYCLES=100; SEG_ACTIVE_LOW=1):
- Bounce: key[0] low for 50 cycles, then high for 3, then held low -> key_state[0] rises 100 cycles after the final settle; exactly one key_press[0] pulse; no pulse on release.
- Mode 0: press key[3] and key[0], i.e. nib = 9 -> cs = FE constant; seg = ~6F = 90; holding key[4] as well -> seg = 10.
- Mode 1: one mode press -> mode = 1; cs steps FE, FD, FB ... 7F, FE every 10 cycles; every digit shows nib.
- Entry: mode = 2; enter nib = 1, 2, 3 -> digits 0/1/2 show 3/2/1 (seg B0/A4/F9); digits 3..7 blank (FF).
- Saturation: 9 entries in mode 2 -> entry_cnt = 8; first entry discarded; the mode press that wraps back to 0 leaves the buffer unchanged on return to mode 2.
- Reset: assert rst mid-scan with a key held -> cs = FF, seg = FF, mode = 0 immediately; after release, key_state re-qualifies only after 100 stable cycles.
